// File: rtl/usr_pkg.sv
// Shared mode encoding and constants for the universal shift register.
package usr_pkg;

  localparam int USR_MODE_W = 2;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD = 2'b00,
    USR_SHR  = 2'b01,
    USR_SHL  = 2'b10,
    USR_LOAD = 2'b11
  } usr_mode_e;

endpackage

// File: rtl/usr_lane.sv
// One WIDTH-bit lane of the universal shift register: register, mode mux, serial outs.
// Define USR_ROTATE_EN to add the rotate input (shifts recirculate the lane's own end bit).
module usr_lane
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [USR_MODE_W-1:0] i_mode,
  input  logic                  i_sin_r,
  input  logic                  i_sin_l,
  input  logic [WIDTH-1:0]      i_pdin,
`ifdef USR_ROTATE_EN
  input  logic                  i_rotate,
`endif
  output logic [WIDTH-1:0]      o_q,
  output logic                  o_sout_r,
  output logic                  o_sout_l
);

  logic [WIDTH-1:0] r_q;
  logic             w_shr_in;
  logic             w_shl_in;

`ifdef USR_ROTATE_EN
  assign w_shr_in = i_rotate ? r_q[0]       : i_sin_r;
  assign w_shl_in = i_rotate ? r_q[WIDTH-1] : i_sin_l;
`else
  assign w_shr_in = i_sin_r;
  assign w_shl_in = i_sin_l;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      case (usr_mode_e'(i_mode))
        USR_SHR:  r_q <= {w_shr_in, r_q[WIDTH-1:1]};
        USR_SHL:  r_q <= {r_q[WIDTH-2:0], w_shl_in};
        USR_LOAD: r_q <= i_pdin;
        default:  r_q <= r_q;
      endcase
    end
  end

  assign o_q      = r_q;
  assign o_sout_r = r_q[0];
  assign o_sout_l = r_q[WIDTH-1];

endmodule

// File: rtl/univ_shift_reg.sv
// Multi-lane universal shift register with a shared word-framing shift counter.
// Define USR_ROTATE_EN to add the rotate input port.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [USR_MODE_W-1:0]  mode,
  input  logic [LANES-1:0]       sin_r,
  input  logic [LANES-1:0]       sin_l,
  input  logic [LANES*WIDTH-1:0] pdin,
`ifdef USR_ROTATE_EN
  input  logic                   rotate,
`endif
  output logic [LANES*WIDTH-1:0] q,
  output logic [LANES-1:0]       sout_r,
  output logic [LANES-1:0]       sout_l,
  output logic                   word_done
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_word_done;
  logic             w_shift;
  logic             w_wrap;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    usr_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_mode   (mode),
      .i_sin_r  (sin_r[g]),
      .i_sin_l  (sin_l[g]),
      .i_pdin   (pdin[g*WIDTH +: WIDTH]),
`ifdef USR_ROTATE_EN
      .i_rotate (rotate),
`endif
      .o_q      (q[g*WIDTH +: WIDTH]),
      .o_sout_r (sout_r[g]),
      .o_sout_l (sout_l[g])
    );
  end

  assign w_shift = (usr_mode_e'(mode) == USR_SHR) || (usr_mode_e'(mode) == USR_SHL);
  assign w_wrap  = w_shift && (r_cnt == CNT_W'(WIDTH - 1));

  // Direction changes share the count; only LOAD or reset restarts a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= w_wrap;
      if (usr_mode_e'(mode) == USR_LOAD) begin
        r_cnt <= '0;
      end else if (w_wrap) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign word_done = r_word_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4, LANES=2) with a reference-model scoreboard.
module tb_univ_shift_reg;

  localparam int WIDTH = 4;
  localparam int LANES = 2;
  localparam int QW    = LANES * WIDTH;
`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [1:0]       mode;
  logic [LANES-1:0] sin_r;
  logic [LANES-1:0] sin_l;
  logic [QW-1:0]    pdin;
  logic             tb_rotate;
  logic [QW-1:0]    q;
  logic [LANES-1:0] sout_r;
  logic [LANES-1:0] sout_l;
  logic             word_done;

  univ_shift_reg #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .pdin      (pdin),
`ifdef USR_ROTATE_EN
    .rotate    (tb_rotate),
`endif
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .word_done (word_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int n_pulses;
  logic [QW:0] exp_q[$];

  // reference model state
  logic [QW-1:0] m_q;
  int            m_cnt;
  logic          m_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q   = '0;
    m_cnt = 0;
    m_wd  = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] m, input logic [LANES-1:0] sr,
                            input logic [LANES-1:0] sl, input logic [QW-1:0] pd,
                            input logic rot);
    logic [QW-1:0] nq;
    nq   = m_q;
    m_wd = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (m == 2'b01) begin
          if (i == WIDTH - 1) nq[k*WIDTH+i] = (ROT_EN && rot) ? m_q[k*WIDTH] : sr[k];
          else                nq[k*WIDTH+i] = m_q[k*WIDTH+i+1];
        end else if (m == 2'b10) begin
          if (i == 0) nq[k*WIDTH+i] = (ROT_EN && rot) ? m_q[k*WIDTH+WIDTH-1] : sl[k];
          else        nq[k*WIDTH+i] = m_q[k*WIDTH+i-1];
        end
      end
    end
    if (m == 2'b11) begin
      nq    = pd;
      m_cnt = 0;
    end
    if (m == 2'b01 || m == 2'b10) begin
      m_cnt++;
      if (m_cnt == WIDTH) begin
        m_cnt = 0;
        m_wd  = 1'b1;
      end
    end
    m_q = nq;
  endtask

  // driver: one clock of stimulus, scoreboard push at drive, pop after the edge
  task automatic step(input logic [1:0] m, input logic [LANES-1:0] sr,
                      input logic [LANES-1:0] sl, input logic [QW-1:0] pd,
                      input logic rot);
    logic [QW:0]      got;
    logic [LANES-1:0] e_sr;
    logic [LANES-1:0] e_sl;
    @(negedge clk);
    mode = m; sin_r = sr; sin_l = sl; pdin = pd; tb_rotate = rot;
    model_step(m, sr, sl, pd, rot);
    exp_q.push_back({m_wd, m_q});
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    for (int k = 0; k < LANES; k++) begin
      e_sr[k] = got[k*WIDTH];
      e_sl[k] = got[k*WIDTH+WIDTH-1];
    end
    check("q", 32'(q), 32'(got[QW-1:0]));
    check("word_done", 32'(word_done), 32'(got[QW]));
    check("sout_r", 32'(sout_r), 32'(e_sr));
    check("sout_l", 32'(sout_l), 32'(e_sl));
    if (word_done) n_pulses++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mode  = 2'b00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // asynchronous reset mid-cycle, checked before the next clock edge
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_q"}, 32'(q), 32'(m_q));
    check({tag, "_wd"}, 32'(word_done), 32'(0));
    check({tag, "_sout"}, 32'({sout_r, sout_l}), 32'(0));
    mode = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [11:0] pulse_mask;
  logic [3:0]  sin_seq;

  initial begin
    n_vec = 0; n_err = 0; n_pulses = 0;
    rst_n = 1'b0; mode = 2'b00; sin_r = '0; sin_l = '0; pdin = '0; tb_rotate = 1'b0;
    model_reset();
    #12;
    check("reset_q", 32'(q), 32'(0));
    check("reset_wd", 32'(word_done), 32'(0));
    check("reset_sout", 32'({sout_r, sout_l}), 32'(0));
    rst_n = 1'b1;

    // LOAD 1011 then 4x SHR with zero fill
    n_pulses = 0;
    step(2'b11, '0, '0, {4'h6, 4'b1011}, 1'b0);
    sin_seq = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      check("t1_sout_r_before", 32'(sout_r[0]), 32'(sin_seq[i]));
      step(2'b01, '0, '0, '0, 1'b0);
    end
    check("t1_final_q", 32'(q[3:0]), 32'(0));
    check("t1_pulses", 32'(n_pulses), 32'(1));

    // SHL fill 1,0,1,1 then a word split by HOLDs
    do_reset();
    n_pulses = 0;
    sin_seq = 4'b1101;
    for (int i = 0; i < 4; i++) step(2'b10, '0, {1'b0, sin_seq[i]}, '0, 1'b0);
    check("t2_q", 32'(q[3:0]), 32'(4'b1011));
    check("t2_pulses_a", 32'(n_pulses), 32'(1));
    step(2'b10, '0, '1, '0, 1'b0);
    step(2'b10, '0, '0, '0, 1'b0);
    step(2'b00, '1, '1, '0, 1'b0);
    step(2'b00, '0, '1, '0, 1'b0);
    step(2'b10, '0, '1, '0, 1'b0);
    check("t2_pulses_b", 32'(n_pulses), 32'(1));
    step(2'b10, '0, '0, '0, 1'b0);
    check("t2_pulses_c", 32'(n_pulses), 32'(2));

    // reset mid-word aborts it
    step(2'b11, '0, '0, 8'hFF, 1'b0);
    step(2'b01, '1, '0, '0, 1'b0);
    step(2'b01, '1, '0, '0, 1'b0);
    mid_reset("t3_abort");
    n_pulses = 0;
    step(2'b01, '1, '0, '0, 1'b0);
    step(2'b10, '0, '1, '0, 1'b0);
    check("t3_no_pulse", 32'(n_pulses), 32'(0));

    // reset while word_done is high clears it at once
    step(2'b01, '0, '0, '0, 1'b0);
    step(2'b01, '0, '0, '0, 1'b0);
    mid_reset("t3_clear_pulse");

    // two lanes are independent
    step(2'b11, '0, '0, {4'hA, 4'h5}, 1'b0);
    step(2'b01, 2'b10, '0, '0, 1'b0);
    check("t4_two_lane", 32'(q), 32'(8'hD2));

    // continuous SHR: pulses on cycles 4, 8, 12 only
    do_reset();
    pulse_mask = '0;
    for (int i = 0; i < 12; i++) begin
      step(2'b01, LANES'($urandom_range(0, 3)), '0, '0, 1'b0);
      pulse_mask[i] = word_done;
    end
    check("t6_pulse_mask", 32'(pulse_mask), 32'(12'h888));

`ifdef USR_ROTATE_EN
    // rotate right ignores sin_r
    do_reset();
    n_pulses = 0;
    step(2'b11, '0, '0, {4'h0, 4'b1000}, 1'b0);
    sin_seq = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step(2'b01, '0, '1, '0, 1'b1);
      check("t5_rot_q", 32'(q[3:0]), 32'(4'b1000 >> ((i + 1) % 4)) | ((i == 3) ? 32'h8 : 32'h0));
    end
    check("t5_rot_pulses", 32'(n_pulses), 32'(1));
`endif

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      step(2'($urandom_range(0, 3)), LANES'($urandom_range(0, 3)), LANES'($urandom_range(0, 3)),
           QW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
